// File: rtl/sobel_pkg.sv
// Shared types, widths and the Sobel magnitude function for the frame controller.
package sobel_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int PIX_W = 8;
   localparam int MAG_W = 12;

   // win[row][col]: row 0 is the top line, col 0 is the leftmost pixel
   typedef logic [2:0][2:0][PIX_W-1:0] win_t;

   function automatic logic [PIX_W-1:0] sobel_mag(input win_t w);
      logic [10:0]        pos_x, neg_x, pos_y, neg_y;
      logic signed [10:0] gx, gy;
      logic [10:0]        ax, ay;
      logic [MAG_W-1:0]   sum;
      pos_x = 11'(w[0][2]) + (11'(w[1][2]) << 1) + 11'(w[2][2]);
      neg_x = 11'(w[0][0]) + (11'(w[1][0]) << 1) + 11'(w[2][0]);
      pos_y = 11'(w[2][0]) + (11'(w[2][1]) << 1) + 11'(w[2][2]);
      neg_y = 11'(w[0][0]) + (11'(w[0][1]) << 1) + 11'(w[0][2]);
      gx    = $signed(pos_x - neg_x);
      gy    = $signed(pos_y - neg_y);
      ax    = gx[10] ? 11'(-gx) : 11'(gx);
      ay    = gy[10] ? 11'(-gy) : 11'(gy);
      sum   = 12'(ax) + 12'(ay);
      return (sum > 12'd255) ? 8'hFF : sum[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One row of pixels, indexed by column; the read returns the value stored before this cycle's write.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH = 640
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [PIX_W-1:0]         wdata,
   output logic [PIX_W-1:0]         rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // NOTE: no reset on the storage array; every entry is written before it is read in a frame.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel datapath: line buffers, window, FSM and a one-entry output register.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [PIX_W-1:0] edge_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   state_t           state, state_nxt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   win_t             win, win_nxt;
   logic [PIX_W-1:0] lb1_rd, lb2_rd;
   logic             accept, last_col, last_pix, load;

   sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
      .clk(clk), .we(accept), .addr(col), .wdata(pix_in), .rdata(lb1_rd)
   );

   sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
      .clk(clk), .we(accept), .addr(col), .wdata(lb1_rd), .rdata(lb2_rd)
   );

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      pix_ready = (state == RUN) && (!out_valid || out_ready);
      accept    = pix_valid && pix_ready;
      last_col  = (col == COL_W'(IMG_WIDTH - 1));
      last_pix  = last_col && (row == ROW_W'(IMG_HEIGHT - 1));
      load      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      busy      = (state != IDLE);
      done      = (state == DRAIN) && out_valid && out_ready;
      win_nxt   = win;
      win_nxt[0] = {lb2_rd, win[0][2], win[0][1]};
      win_nxt[1] = {lb1_rd, win[1][2], win[1][1]};
      win_nxt[2] = {pix_in, win[2][2], win[2][1]};
      case (state)
         IDLE:    if (start)              state_nxt = RUN;
         RUN:     if (accept && last_pix) state_nxt = DRAIN;
         DRAIN:   if (done)               state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         win       <= '0;
         edge_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
            win <= '0;
         end else if (accept) begin
            win <= win_nxt;
            if (last_col) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
         // A new load wins over acceptance, so back-to-back outputs keep out_valid high
         if (load) begin
            edge_out  <= sobel_mag(win_nxt);
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 5x4 frame with hand-computed edge values.
module tb_sobel_frame_ctrl;

   localparam int W     = 5;
   localparam int H     = 4;
   localparam int N_OUT = (W - 2) * (H - 2);

   logic       clk = 1'b0;
   logic       rst, start, pix_valid, out_ready;
   logic [7:0] pix_in;
   logic       pix_ready, out_valid, busy, done;
   logic [7:0] edge_out;

   int n_tests = 0;
   int n_fail  = 0;

   // expected outputs, row-major over the interior, one row per frame kind
   int exp_tab [4][N_OUT] = '{
      '{0,   0,   0, 0,   0,   0},
      '{255, 255, 0, 255, 255, 0},
      '{40,  40,  0, 40,  40,  0},
      '{80,  80,  80, 80, 80,  80}
   };

   sobel_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .edge_out(edge_out), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
      case (kind)
         0:       return 8'd100;
         1:       return (c >= 2) ? 8'd255 : 8'd0;
         2:       return (c >= 2) ? 8'd10 : 8'd0;
         default: return (r >= 2) ? 8'd20 : 8'd0;
      endcase
   endfunction

   task automatic run_frame(input int kind, input int stall, input bit mid_start, input string name);
      int         idx = 0, nout = 0, ndone = 0, cyc = 0, stall_left = stall;
      logic [7:0] held = '0;
      bit         finished = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " busy_after_start"}, busy, 1);
      while (!finished && cyc < 500) begin
         pix_valid = (idx < W * H);
         pix_in    = pix_of(kind, idx / W, idx % W);
         start     = mid_start && (idx == 7);
         out_ready = 1'b1;
         if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            if (stall_left == stall) held = edge_out;
         end
         #1;
         if (!out_ready) begin
            check({name, " stall_pix_ready"}, pix_ready, 0);
            check({name, " stall_edge_hold"}, edge_out, held);
            stall_left--;
         end
         if (out_valid && out_ready) begin
            if (nout < N_OUT) check($sformatf("%s out%0d", name, nout), edge_out, exp_tab[kind][nout]);
            nout++;
         end
         if (done) begin
            ndone++;
            finished = 1'b1;
         end
         if (pix_valid && pix_ready) idx++;
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      check({name, " finished"}, finished, 1);
      check({name, " out_count"}, nout, N_OUT);
      check({name, " done_count"}, ndone, 1);
      check({name, " busy_drop"}, busy, 0);
      check({name, " done_low"}, done, 0);
      pix_valid = 1'b0;
   endtask

   task automatic abort_frame();
      int idx = 0, ndone = 0, cyc = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < 9 && cyc < 100) begin
         pix_valid = 1'b1;
         pix_in    = pix_of(1, idx / W, idx % W);
         #1;
         if (done) ndone++;
         if (pix_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      pix_valid = 1'b0;
      check("abort pixels_sent", idx, 9);
      rst = 1'b1;
      #1;
      check("abort pix_ready", pix_ready, 0);
      check("abort out_valid", out_valid, 0);
      check("abort edge_out", edge_out, 0);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort no_done", ndone, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort idle_after", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      pix_in    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset pix_ready", pix_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset edge_out", edge_out, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      rst = 1'b0;

      run_frame(0, 0, 1'b0, "flat");
      run_frame(1, 0, 1'b0, "vstep255");
      run_frame(2, 0, 1'b0, "vstep10");
      run_frame(3, 0, 1'b0, "hstep20");
      run_frame(1, 5, 1'b0, "stall");
      abort_frame();
      run_frame(2, 0, 1'b0, "after_reset");
      run_frame(3, 0, 1'b1, "mid_start");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Streaming controller that sequences a full greyscale frame through the 3x3 Sobel edge datapath. It accepts raster-order 8-bit pixels with a valid/ready handshake and keeps two line buffers plus a 3x3 window. For every interior pixel it emits one saturated 8-bit edge magnitude |Gx|+|Gy| under output backpressure. It sits between the camera/frame source and the edge-map writer.

## Interface
Clock: single clock `clk`. Reset: `rst`, asynchronous, active-high.

Parameters:
- `IMG_WIDTH`, default 640: pixels per row; must be at least 3.
- `IMG_HEIGHT`, default 480: rows per frame; must be at least 3.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `pix_in`  in  8  input pixel, raster order
- `pix_valid`  in  1  `pix_in` is valid
- `pix_ready`  out  1  controller accepts `pix_in` this cycle
- `edge_out`  out  8  edge magnitude, saturated to 255
- `out_valid`  out  1  `edge_out` is valid
- `out_ready`  in  1  downstream accepts `edge_out`
- `busy`  out  1  a frame is in progress
- `done`  out  1  one-cycle pulse after the last output is accepted

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN on `start`. This clears the column and row counters and the window.
  - RUN → DRAIN when pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - DRAIN → IDLE when `out_valid && out_ready`. `done` pulses in that same cycle.
- `start` is ignored outside IDLE.
- Pixel acceptance: a pixel is accepted when `pix_valid && pix_ready`. `pix_ready` is `(state==RUN) && (!out_valid || out_ready)`.
- Counters on each accepted pixel:
  - The column counter increments and wraps from IMG_WIDTH-1 to 0. On wrap, the row counter increments.
  - A pixel arriving at column c goes into the window and both line buffers.
  - Line buffer 1 holds row r-1 and line buffer 2 holds row r-2, each indexed by c.
- Window: three 3-column shift registers.
  - The top row shifts in from line buffer 2, the middle row from line buffer 1, and the bottom row from `pix_in`.
  - Column 0 of the window is the leftmost pixel.
- Output generation:
  - An accepted pixel at (r,c) with r≥2 and c≥2 completes the window centred at (r-1,c-1). It produces exactly one output.
  - All other pixels produce no output. Border pixels are never emitted.
  - A frame therefore yields (IMG_WIDTH-2)·(IMG_HEIGHT-2) outputs.
- Arithmetic:
  - Gx = (TR+2·MR+BR) − (TL+2·ML+BL).
  - Gy = (BL+2·BC+BR) − (TL+2·TC+TR).
  - Both are computed in 11-bit signed. The sum |Gx|+|Gy| is computed in 12-bit unsigned, maximum 2040.
  - `edge_out` = min(sum, 255).
- Output register:
  - One entry, holding `edge_out` and `out_valid`.
  - It is loaded when a window completes. It clears when accepted with no new load.
  - `edge_out` is held stable while `out_valid && !out_ready`.
- Line buffer contents need no reset. They are overwritten before they are read in every frame.

## Timing
- Reset values: state IDLE, `pix_ready` 0, `out_valid` 0, `edge_out` 0, `busy` 0, `done` 0. Counters and window are 0.
- Reset asserted mid-frame abandons the frame immediately. No `done` is produced.
- Latency: the output for a completing pixel is valid the cycle after acceptance.
- Throughput is one pixel per cycle with `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, `pix_ready` is 0 and no counter or window state changes.
- Simultaneous events: acceptance of the old output and loading of a new one in the same cycle is legal. `out_valid` stays 1 and the new value appears.
- `busy` is 1 from the cycle after `start` through the cycle `done` is asserted.
- Line buffer read and write at the same column in the same cycle must return the old data (read-before-write).

## Structure
- Shared package `sobel_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DRAIN);
  - `PIX_W`=8 and `MAG_W`=12;
  - function `sobel_mag(window)` returning the saturated 8-bit magnitude.
- Sub-module `sobel_line_buffer`: one IMG_WIDTH×8 read-before-write memory with a write enable. Instantiate it twice.
- The top level holds the FSM, counters, window registers and output register.

## Test plan
All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4 unless stated.
- Flat frame, all pixels 100, `out_ready` high → exactly 6 outputs, all 0. `done` pulses once, `busy` drops the following cycle.
- Vertical step, columns 0–1 = 0 and columns 2–4 = 255 → each output row is 255, 255, 0 (saturated).
- Small vertical step, columns 0–1 = 0 and columns 2–4 = 10 → each output row is 40, 40, 0.
- Horizontal step, rows 0–1 = 0 and rows 2–3 = 20:
  - output row 1 reads 80, 80, 80;
  - output row 2 reads 80, 80, 80 (window rows 1/3 = 0/20).
- Backpressure: hold `out_ready` low for 5 cycles on the first output → `pix_ready` is 0 and `edge_out` is stable. The output sequence is unchanged from the unstalled run.
- Reset and start handling:
  - assert `rst` after 9 pixels → all outputs return to reset values;
  - a new `start` then produces a correct full frame;
  - `start` pulsed during RUN has no effect.
